// File: rtl/midi_cmd_encoder.sv
// MIDI byte-stream parser that turns note-on/off and all-notes-off messages into 16-bit
// commands, queued in a FIFO and written out over an Avalon-MM master. Option: MIDI_CHANNEL_FILTER_EN.
module midi_cmd_encoder #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      i_midi_byte,
    input  logic                            i_midi_valid,
    output logic                            avm_m0_write,
    output logic [31:0]                     avm_m0_writedata,
    input  logic                            avm_m0_waitrequest,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
    output logic                            o_overflow
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef MIDI_CHANNEL_FILTER_EN
    localparam logic FILTER_EN = 1'b1;
`else
    localparam logic FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } state_t;

    state_t         state_r, state_next_s;
    logic [7:0]     status_r, status_next_s;
    logic [6:0]     d1_r, d1_next_s;
    logic [6:0]     d2_s;
    logic           done_s, cmd_hit_s, ch_ok_s;
    logic [15:0]    cmd_s, cmd_r;
    logic           cmd_valid_r;

    logic [15:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CW-1:0]  count_r, count_next_s;
    logic           pop_s, full_s, push_s, drop_s;
    logic           write_r, overflow_r;
    logic [15:0]    writedata_r, head_next_s;

    assign ch_ok_s = ~FILTER_EN | (status_r[3:0] == MIDI_CHANNEL);

    // Byte classification and parser next-state
    always_comb begin
        state_next_s  = state_r;
        status_next_s = status_r;
        d1_next_s     = d1_r;
        d2_s          = 7'd0;
        done_s        = 1'b0;
        // Realtime bytes (F8-FF) fall through untouched, even mid-message
        if (i_midi_valid && (i_midi_byte[7:3] != 5'b11111)) begin
            if (i_midi_byte[7:4] == 4'hF) begin
                status_next_s = 8'h00;
                state_next_s  = ST_IDLE;
            end else if (i_midi_byte[7]) begin
                status_next_s = i_midi_byte;
                state_next_s  = ST_WAIT_D1;
            end else begin
                case (state_r)
                    ST_WAIT_D1: begin
                        if ((status_r[7:4] == 4'hC) || (status_r[7:4] == 4'hD)) begin
                            done_s = 1'b1;
                        end else begin
                            d1_next_s    = i_midi_byte[6:0];
                            state_next_s = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        d2_s         = i_midi_byte[6:0];
                        done_s       = 1'b1;
                        state_next_s = ST_WAIT_D1;
                    end
                    default: begin
                        state_next_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Command encoding for a completed message; note 127 is reserved for STOP_ALL
    always_comb begin
        cmd_s     = 16'h0000;
        cmd_hit_s = 1'b0;
        case (status_r[7:4])
            4'h9: begin
                if (d1_r != 7'h7F) begin
                    cmd_hit_s = 1'b1;
                    cmd_s = (d2_s != 7'd0) ? {1'b1, d1_r, 1'b0, d2_s} : {1'b0, d1_r, 8'h00};
                end else begin
                    cmd_hit_s = 1'b0;
                end
            end
            4'h8: begin
                if (d1_r != 7'h7F) begin
                    cmd_hit_s = 1'b1;
                    cmd_s     = {1'b0, d1_r, 8'h00};
                end else begin
                    cmd_hit_s = 1'b0;
                end
            end
            4'hB: begin
                if (d1_r == 7'd123) begin
                    cmd_hit_s = 1'b1;
                    cmd_s     = {1'b0, 7'h7F, 8'h00};
                end else begin
                    cmd_hit_s = 1'b0;
                end
            end
            default: begin
                cmd_hit_s = 1'b0;
            end
        endcase
    end

    // Parser state and registered command stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            status_r    <= 8'h00;
            d1_r        <= 7'h00;
            cmd_r       <= 16'h0000;
            cmd_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            status_r    <= status_next_s;
            d1_r        <= d1_next_s;
            cmd_r       <= cmd_s;
            cmd_valid_r <= done_s & cmd_hit_s & ch_ok_s;
        end
    end

    // FIFO control; a full FIFO still accepts a push when the head leaves the same cycle
    always_comb begin
        pop_s         = write_r & ~avm_m0_waitrequest;
        full_s        = (count_r == DEPTH_C);
        push_s        = cmd_valid_r & (~full_s | pop_s);
        drop_s        = cmd_valid_r & full_s & ~pop_s;
        wr_ptr_next_s = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        rd_ptr_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        // The entry being written this edge bypasses the array when it becomes the head
        if (count_next_s == CW'(0)) begin
            head_next_s = 16'h0000;
        end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = cmd_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Command storage; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_r;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered Avalon outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            write_r     <= 1'b0;
            writedata_r <= 16'h0000;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            overflow_r  <= overflow_r | drop_s;
            write_r     <= (count_next_s != CW'(0));
            writedata_r <= head_next_s;
        end
    end

    assign avm_m0_write     = write_r;
    assign avm_m0_writedata = {16'h0000, writedata_r};
    assign o_fifo_count     = count_r;
    assign o_overflow       = overflow_r;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// Directed self-checking bench for midi_cmd_encoder (FIFO_DEPTH=4, MIDI_CHANNEL=0).
module tb_midi_cmd_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_midi_byte;
    logic        i_midi_valid;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_waitrequest;
    logic [2:0]  o_fifo_count;
    logic        o_overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] got_q[$];

    midi_cmd_encoder #(.FIFO_DEPTH(4), .MIDI_CHANNEL(4'd0)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_midi_byte        (i_midi_byte),
        .i_midi_valid       (i_midi_valid),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest),
        .o_fifo_count       (o_fifo_count),
        .o_overflow         (o_overflow)
    );

    always #5 clk = ~clk;

    // Record every write the slave accepts at the coming rising edge
    always @(negedge clk) begin
        if (!reset && avm_m0_write && !avm_m0_waitrequest) got_q.push_back(avm_m0_writedata);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_midi_byte  = b;
        i_midi_valid = 1'b1;
        tick(1);
        i_midi_valid = 1'b0;
        i_midi_byte  = 8'h00;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_checks++; if (avm_m0_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b exp 0", avm_m0_write); end
        n_checks++; if (avm_m0_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", avm_m0_writedata); end
        n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_fifo_count); end
        n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", o_overflow); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_note_on;
        got_q.delete();
        send(8'h90); send(8'h24); send(8'h40);
        n_checks++; if (avm_m0_write !== 1'b0) begin n_fail++; $display("FAIL note_on_early got %b exp 0", avm_m0_write); end
        tick(1);
        n_checks++; if (avm_m0_write !== 1'b1) begin n_fail++; $display("FAIL note_on_write got %b exp 1", avm_m0_write); end
        n_checks++; if (avm_m0_writedata !== 32'h0000_A440) begin n_fail++; $display("FAIL note_on_wdata got %h exp 0000a440", avm_m0_writedata); end
        n_checks++; if (o_fifo_count !== 3'd1) begin n_fail++; $display("FAIL note_on_count1 got %0d exp 1", o_fifo_count); end
        tick(1);
        n_checks++; if (avm_m0_write !== 1'b0) begin n_fail++; $display("FAIL note_on_done got %b exp 0", avm_m0_write); end
        n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL note_on_count0 got %0d exp 0", o_fifo_count); end
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL note_on_nwrites got %0d exp 1", got_q.size()); end
    endtask

    task automatic test_running_status;
        logic [31:0] exp_w [2];
        exp_w[0] = 32'h0000_A950;
        exp_w[1] = 32'h0000_2900;
        got_q.delete();
        send(8'h90); send(8'h29); send(8'h50); send(8'h29); send(8'h00);
        tick(5);
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL running_nwrites got %0d exp 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL running_w%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_note_off_stop_all;
        logic [31:0] exp_w [2];
        exp_w[0] = 32'h0000_4500;
        exp_w[1] = 32'h0000_7F00;
        got_q.delete();
        send(8'h80); send(8'h45); send(8'h3C); send(8'hB0); send(8'h7B); send(8'h00);
        tick(5);
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL off_stop_nwrites got %0d exp 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL off_stop_w%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_w[i]);
            end
        end
        got_q.delete();
        send(8'h90); send(8'h7F); send(8'h40);
        tick(4);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL note127_nwrites got %0d exp 0", got_q.size()); end
    endtask

    task automatic test_realtime_sysex;
        got_q.delete();
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h40);
        tick(4);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL realtime_nwrites got %0d exp 1", got_q.size()); end
        n_checks++;
        if (got_q.size() < 1 || got_q[0] !== 32'h0000_BC40) begin
            n_fail++; $display("FAIL realtime_w0 got %h exp 0000bc40", (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx);
        end
        got_q.delete();
        send(8'hF0); send(8'h24); send(8'h40); send(8'hF7); send(8'h24); send(8'h40);
        tick(4);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL sysex_nwrites got %0d exp 0", got_q.size()); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0000_BC40;
        exp_w[1] = 32'h0000_BE40;
        exp_w[2] = 32'h0000_C040;
        exp_w[3] = 32'h0000_C140;
        got_q.delete();
        avm_m0_waitrequest = 1'b1;
        send(8'h90); send(8'h3C); send(8'h40); send(8'h3E); send(8'h40); send(8'h40);
        send(8'h40); send(8'h41); send(8'h40); send(8'h43); send(8'h40);
        tick(2);
        n_checks++; if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", o_fifo_count); end
        n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", o_overflow); end
        n_checks++; if (avm_m0_write !== 1'b1) begin n_fail++; $display("FAIL ovf_write_held got %b exp 1", avm_m0_write); end
        n_checks++; if (avm_m0_writedata !== 32'h0000_BC40) begin n_fail++; $display("FAIL ovf_wdata_held got %h exp 0000bc40", avm_m0_writedata); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_stalled_nwrites got %0d exp 0", got_q.size()); end
        avm_m0_waitrequest = 1'b0;
        tick(6);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL ovf_drain_nwrites got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL ovf_drain_w%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_w[i]);
            end
        end
        n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drain_count got %0d exp 0", o_fifo_count); end
        n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", o_overflow); end
    endtask

    task automatic test_channel_filter;
        got_q.delete();
        send(8'h91); send(8'h24); send(8'h40);
        tick(4);
`ifdef MIDI_CHANNEL_FILTER_EN
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL filter_ch1_nwrites got %0d exp 0", got_q.size()); end
`else
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL omni_ch1_nwrites got %0d exp 1", got_q.size()); end
`endif
        got_q.delete();
        send(8'h90); send(8'h24); send(8'h40);
        tick(4);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'h0000_A440) begin
            n_fail++; $display("FAIL filter_ch0 got %0d writes first %h exp 1 write 0000a440", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx);
        end
    endtask

    task automatic test_reset_mid_stall;
        avm_m0_waitrequest = 1'b1;
        send(8'h90); send(8'h24); send(8'h40);
        tick(2);
        n_checks++; if (avm_m0_write !== 1'b1) begin n_fail++; $display("FAIL stall_write got %b exp 1", avm_m0_write); end
        send(8'h90); send(8'h24);
        reset = 1'b1;
        tick(1);
        n_checks++; if (avm_m0_write !== 1'b0) begin n_fail++; $display("FAIL rst_stall_write got %b exp 0", avm_m0_write); end
        n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_stall_count got %0d exp 0", o_fifo_count); end
        n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_stall_ovf got %b exp 0", o_overflow); end
        reset = 1'b0;
        avm_m0_waitrequest = 1'b0;
        got_q.delete();
        send(8'h40); send(8'h40);
        tick(4);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_abandon_nwrites got %0d exp 0", got_q.size()); end
    endtask

    initial begin
        reset              = 1'b1;
        i_midi_byte        = 8'h00;
        i_midi_valid       = 1'b0;
        avm_m0_waitrequest = 1'b0;
        #1;
        test_reset();
        test_note_on();
        test_running_status();
        test_note_off_stop_all();
        test_realtime_sysex();
        test_overflow();
        test_channel_filter();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
